// File: rtl/nv_ram_rws_512x256_fifo_ctrl_if.sv
// nv_ram_rws_512x256_fifo_ctrl_if
// Valid/ready stream bundle used for both the producer (push) side and the
// consumer (pop) side of the FIFO controller.
//   master: drives valid/data, receives ready
//   slave : receives valid/data, drives ready
interface nv_ram_rws_512x256_fifo_ctrl_if #(
  parameter int DW = 256
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/nv_ram_rws_512x256_fifo_ctrl.sv
// nv_ram_rws_512x256_fifo_ctrl
// Runs one external two-port RAM (registered read address, 1-cycle read) as a
// valid/ready FIFO. Reads are issued ahead of demand into a 2-entry output
// buffer so the consumer can pop one word per cycle without bubbles.
// Optional feature: define NV_RAM_FIFO_CTRL_FLUSH_EN to add a synchronous
// flush input that empties the FIFO at the next edge.
module nv_ram_rws_512x256_fifo_ctrl #(
  parameter int DEPTH = 512,
  parameter int AW    = 9,
  parameter int DW    = 256
) (
  input  logic                           clk,
  input  logic                           rst,
  nv_ram_rws_512x256_fifo_ctrl_if.slave  wr,
  nv_ram_rws_512x256_fifo_ctrl_if.master rd,
  output logic [AW-1:0]                  ram_wa,
  output logic                           ram_we,
  output logic [DW-1:0]                  ram_di,
  output logic [AW-1:0]                  ram_ra,
  output logic                           ram_re,
  input  logic [DW-1:0]                  ram_dout,
  output logic [AW:0]                    ram_used,
  output logic [AW+2:0]                  fifo_count,
  input  logic [31:0]                    pwrbus_ram_pd,
  output logic [31:0]                    ram_pwrbus_pd
`ifdef NV_RAM_FIFO_CTRL_FLUSH_EN
  ,
  input  logic                           flush
`endif
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  // Registered state
  logic [AW-1:0]  wr_ptr_r,   rd_ptr_r;
  logic [AW:0]    used_r;
  logic           inflight_r;
  logic [1:0]     ob_cnt_r;
  logic [DW-1:0]  ob0_r,      ob1_r;
  logic [AW+2:0]  count_r;

  // Next-state values
  logic [AW-1:0]  wr_ptr_nxt, rd_ptr_nxt;
  logic [AW:0]    used_nxt;
  logic           inflight_nxt;
  logic [1:0]     ob_cnt_nxt;
  logic [DW-1:0]  ob0_nxt,    ob1_nxt;
  logic [AW+2:0]  count_nxt;

  // Handshake decode
  logic           flush_en;
  logic           push;
  logic           pop;
  logic           rd_issue;
  logic [2:0]     occ;
  logic [2:0]     occ_limit;

`ifdef NV_RAM_FIFO_CTRL_FLUSH_EN
  assign flush_en = flush;
`else
  assign flush_en = 1'b0;
`endif

  // Space is judged from registered occupancy only; a pop in the same cycle
  // does not create room for a push.
  assign wr.ready  = !rst && !flush_en && (used_r < FULL);
  assign rd.valid  = (ob_cnt_r != 2'd0) && !flush_en;
  assign rd.data   = ob0_r;

  assign push      = wr.valid && wr.ready;
  assign pop       = rd.valid && rd.ready;

  // Issue a read only if its word is guaranteed a buffer slot when it lands:
  // buffered + in-flight - leaving this cycle must stay below 2.
  assign occ       = {1'b0, ob_cnt_r} + {2'b00, inflight_r};
  assign occ_limit = 3'd2 + {2'b00, pop};
  assign rd_issue  = !flush_en && (used_r != {(AW+1){1'b0}}) && (occ < occ_limit);

  assign ram_wa        = wr_ptr_r;
  assign ram_we        = push;
  assign ram_di        = wr.data;
  assign ram_ra        = rd_ptr_r;
  assign ram_re        = rd_issue;
  assign ram_used      = used_r;
  assign fifo_count    = count_r;
  assign ram_pwrbus_pd = pwrbus_ram_pd;

  // Next-state: pointers, RAM occupancy, read-in-flight flag and output buffer
  always_comb begin
    wr_ptr_nxt   = wr_ptr_r;
    rd_ptr_nxt   = rd_ptr_r;
    used_nxt     = used_r;
    inflight_nxt = rd_issue;
    ob_cnt_nxt   = ob_cnt_r;
    ob0_nxt      = ob0_r;
    ob1_nxt      = ob1_r;

    if (flush_en) begin
      wr_ptr_nxt   = {AW{1'b0}};
      rd_ptr_nxt   = {AW{1'b0}};
      used_nxt     = {(AW+1){1'b0}};
      inflight_nxt = 1'b0;
      ob_cnt_nxt   = 2'd0;
    end else begin
      // Pointers wrap naturally because DEPTH == 2**AW
      if (push) begin
        wr_ptr_nxt = wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_nxt = wr_ptr_r;
      end

      if (rd_issue) begin
        rd_ptr_nxt = rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_nxt = rd_ptr_r;
      end

      case ({push, rd_issue})
        2'b10:   used_nxt = used_r + (AW+1)'(1);
        2'b01:   used_nxt = used_r - (AW+1)'(1);
        default: used_nxt = used_r;
      endcase

      // Output buffer: ob0 is the head; a captured word goes to the tail
      case ({pop, inflight_r})
        2'b11: begin
          if (ob_cnt_r == 2'd2) begin
            ob0_nxt = ob1_r;
            ob1_nxt = ram_dout;
          end else begin
            ob0_nxt = ram_dout;
          end
        end
        2'b10: begin
          ob0_nxt    = ob1_r;
          ob_cnt_nxt = ob_cnt_r - 2'd1;
        end
        2'b01: begin
          if (ob_cnt_r == 2'd0) begin
            ob0_nxt = ram_dout;
          end else begin
            ob1_nxt = ram_dout;
          end
          ob_cnt_nxt = ob_cnt_r + 2'd1;
        end
        default: begin
          ob_cnt_nxt = ob_cnt_r;
        end
      endcase
    end

    count_nxt = (AW+3)'(used_nxt) + (AW+3)'(inflight_nxt) + (AW+3)'(ob_cnt_nxt);
  end

  // State registers with asynchronous reset discarding all contents
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      used_r     <= {(AW+1){1'b0}};
      inflight_r <= 1'b0;
      ob_cnt_r   <= 2'd0;
      ob0_r      <= {DW{1'b0}};
      ob1_r      <= {DW{1'b0}};
      count_r    <= {(AW+3){1'b0}};
    end else begin
      wr_ptr_r   <= wr_ptr_nxt;
      rd_ptr_r   <= rd_ptr_nxt;
      used_r     <= used_nxt;
      inflight_r <= inflight_nxt;
      ob_cnt_r   <= ob_cnt_nxt;
      ob0_r      <= ob0_nxt;
      ob1_r      <= ob1_nxt;
      count_r    <= count_nxt;
    end
  end

endmodule

// File: tb/tb_nv_ram_rws_512x256_fifo_ctrl.sv
// tb_nv_ram_rws_512x256_fifo_ctrl
// Directed bench for the RAM FIFO controller with a behavioural RAM model
// (registered read address, combinational array read after the latch).
module tb_nv_ram_rws_512x256_fifo_ctrl;
  localparam int AW = 9;
  localparam int DW = 256;

  logic          clk;
  logic          rst;
  logic [AW-1:0] ram_wa, ram_ra;
  logic          ram_we, ram_re;
  logic [DW-1:0] ram_di, ram_dout;
  logic [AW:0]   ram_used;
  logic [AW+2:0] fifo_count;
  logic [31:0]   pwrbus_ram_pd, ram_pwrbus_pd;
`ifdef NV_RAM_FIFO_CTRL_FLUSH_EN
  logic          flush;
`endif

  nv_ram_rws_512x256_fifo_ctrl_if #(.DW(DW)) wr_if ();
  nv_ram_rws_512x256_fifo_ctrl_if #(.DW(DW)) rd_if ();

  nv_ram_rws_512x256_fifo_ctrl #(.DEPTH(512), .AW(AW), .DW(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .wr            (wr_if),
    .rd            (rd_if),
    .ram_wa        (ram_wa),
    .ram_we        (ram_we),
    .ram_di        (ram_di),
    .ram_ra        (ram_ra),
    .ram_re        (ram_re),
    .ram_dout      (ram_dout),
    .ram_used      (ram_used),
    .fifo_count    (fifo_count),
    .pwrbus_ram_pd (pwrbus_ram_pd),
    .ram_pwrbus_pd (ram_pwrbus_pd)
`ifdef NV_RAM_FIFO_CTRL_FLUSH_EN
    ,
    .flush         (flush)
`endif
  );

  // RAM model
  logic [DW-1:0] mem [0:511];
  logic [AW-1:0] ra_q;
  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    if (ram_re) ra_q <= ram_ra;
  end
  assign ram_dout = mem[ra_q];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard / model state
  logic [DW-1:0] sb[$];
  int mcount;
  int mwp;
  int mrp;
  int nvec;
  int nerr;

  task automatic clear_model();
    sb.delete();
    mcount = 0;
    mwp = 0;
    mrp = 0;
  endtask

  // Advance one clock, updating the model with what happened at the edge
  task automatic tick();
    logic do_push, do_pop, do_re;
    do_push = wr_if.valid && wr_if.ready;
    do_pop  = rd_if.valid && rd_if.ready;
    do_re   = ram_re;
    @(posedge clk);
    if (do_push) begin
      sb.push_back(wr_if.data);
      mcount++;
      mwp = (mwp + 1) % 512;
    end
    if (do_pop) begin
      if (sb.size() != 0) void'(sb.pop_front());
      mcount--;
    end
    if (do_re) mrp = (mrp + 1) % 512;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr_if.valid = 1'b1;
    wr_if.data = {8{32'hDEAD_BEEF}};
    rd_if.ready = 1'b1;
    pwrbus_ram_pd = 32'h1234_5678;
    repeat (2) @(posedge clk);
    #1;
    nvec++; if (wr_if.ready !== 1'b0) begin nerr++; $display("FAIL reset_wr_ready: got %0b want 0", wr_if.ready); end
    nvec++; if (ram_we !== 1'b0) begin nerr++; $display("FAIL reset_ram_we: got %0b want 0", ram_we); end
    nvec++; if (rd_if.valid !== 1'b0) begin nerr++; $display("FAIL reset_rd_valid: got %0b want 0", rd_if.valid); end
    nvec++; if (ram_re !== 1'b0) begin nerr++; $display("FAIL reset_ram_re: got %0b want 0", ram_re); end
    nvec++; if (fifo_count !== 12'd0) begin nerr++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    nvec++; if (rd_if.data !== {DW{1'b0}}) begin nerr++; $display("FAIL reset_rd_data: got %0h want 0", rd_if.data); end
    nvec++; if (ram_wa !== 9'd0 || ram_ra !== 9'd0) begin nerr++; $display("FAIL reset_ptrs: got wa=%0d ra=%0d want 0 0", ram_wa, ram_ra); end
    nvec++; if (ram_pwrbus_pd !== 32'h1234_5678) begin nerr++; $display("FAIL pwrbus: got %0h want 12345678", ram_pwrbus_pd); end
    wr_if.valid = 1'b0;
    rst = 1'b0;
    #1;
    nvec++; if (wr_if.ready !== 1'b1) begin nerr++; $display("FAIL release_wr_ready: got %0b want 1", wr_if.ready); end
    clear_model();
  endtask

  task automatic test_single();
    wr_if.data = {32{8'hA5}};
    wr_if.valid = 1'b1;
    rd_if.ready = 1'b1;
    #1;
    nvec++; if (ram_we !== 1'b1 || ram_wa !== 9'd0) begin nerr++; $display("FAIL single_write: got we=%0b wa=%0d want 1 0", ram_we, ram_wa); end
    tick();
    wr_if.valid = 1'b0;
    #1;
    nvec++; if (fifo_count !== 12'd1) begin nerr++; $display("FAIL single_cnt_t0: got %0d want 1", fifo_count); end
    nvec++; if (ram_re !== 1'b1 || ram_ra !== 9'd0) begin nerr++; $display("FAIL single_re: got re=%0b ra=%0d want 1 0", ram_re, ram_ra); end
    nvec++; if (rd_if.valid !== 1'b0) begin nerr++; $display("FAIL single_valid_t0: got %0b want 0", rd_if.valid); end
    tick();
    nvec++; if (fifo_count !== 12'd1) begin nerr++; $display("FAIL single_cnt_t1: got %0d want 1", fifo_count); end
    nvec++; if (rd_if.valid !== 1'b0) begin nerr++; $display("FAIL single_valid_t1: got %0b want 0", rd_if.valid); end
    tick();
    nvec++; if (rd_if.valid !== 1'b1) begin nerr++; $display("FAIL single_valid_t2: got %0b want 1", rd_if.valid); end
    nvec++; if (rd_if.data !== {32{8'hA5}}) begin nerr++; $display("FAIL single_data: got %0h want a5..", rd_if.data); end
    nvec++; if (fifo_count !== 12'd1) begin nerr++; $display("FAIL single_cnt_t2: got %0d want 1", fifo_count); end
    tick();
    nvec++; if (fifo_count !== 12'd0 || rd_if.valid !== 1'b0) begin nerr++; $display("FAIL single_drained: got cnt=%0d valid=%0b want 0 0", fifo_count, rd_if.valid); end
  endtask

  task automatic test_fill();
    rd_if.ready = 1'b0;
    for (int i = 0; i < 514; i++) begin
      wr_if.valid = 1'b1;
      wr_if.data = {8{32'h1000_0000 + 32'(i)}};
      #1;
      nvec++; if (wr_if.ready !== 1'b1) begin nerr++; $display("FAIL fill_ready word %0d: got %0b want 1", i, wr_if.ready); end
      tick();
      if (i == 511) begin
        nvec++; if (ram_used !== 10'd510 || fifo_count !== 12'd512) begin nerr++; $display("FAIL fill_512: got used=%0d cnt=%0d want 510 512", ram_used, fifo_count); end
      end
    end
    wr_if.data = {8{32'hFFFF_FFFF}};
    #1;
    nvec++; if (wr_if.ready !== 1'b0) begin nerr++; $display("FAIL full_wr_ready: got %0b want 0", wr_if.ready); end
    nvec++; if (ram_we !== 1'b0) begin nerr++; $display("FAIL full_ram_we: got %0b want 0", ram_we); end
    nvec++; if (fifo_count !== 12'd514 || ram_used !== 10'd512) begin nerr++; $display("FAIL full_count: got cnt=%0d used=%0d want 514 512", fifo_count, ram_used); end
    nvec++; if (rd_if.valid !== 1'b1 || rd_if.data !== {8{32'h1000_0000}}) begin nerr++; $display("FAIL full_head: got valid=%0b data=%0h want 1 10000000..", rd_if.valid, rd_if.data); end
    tick();
    nvec++; if (fifo_count !== 12'd514) begin nerr++; $display("FAIL full_hold: got %0d want 514", fifo_count); end
  endtask

  task automatic test_back_to_back();
    rd_if.ready = 1'b1;
    for (int i = 0; i < 600; i++) begin
      wr_if.valid = 1'b1;
      wr_if.data = {8{32'h2000_0000 + 32'(i)}};
      #1;
      nvec++; if (rd_if.valid !== 1'b1) begin nerr++; $display("FAIL stream_gap cycle %0d: got %0b want 1", i, rd_if.valid); end
      nvec++; if (sb.size() == 0 || rd_if.data !== sb[0]) begin nerr++; $display("FAIL stream_data cycle %0d: got %0h want %0h", i, rd_if.data, (sb.size() != 0) ? sb[0] : {DW{1'b0}}); end
      if (ram_we) begin
        nvec++; if (ram_wa !== 9'(mwp)) begin nerr++; $display("FAIL stream_wa: got %0d want %0d", ram_wa, mwp); end
      end
      if (ram_re) begin
        nvec++; if (ram_ra !== 9'(mrp)) begin nerr++; $display("FAIL stream_ra: got %0d want %0d", ram_ra, mrp); end
      end
      tick();
      nvec++; if (fifo_count !== 12'(mcount)) begin nerr++; $display("FAIL stream_count: got %0d want %0d", fifo_count, mcount); end
    end
    wr_if.valid = 1'b0;
    for (int k = 0; k < 700 && mcount != 0; k++) begin
      #1;
      if (rd_if.valid) begin
        nvec++; if (sb.size() == 0 || rd_if.data !== sb[0]) begin nerr++; $display("FAIL drain_data: got %0h want %0h", rd_if.data, (sb.size() != 0) ? sb[0] : {DW{1'b0}}); end
      end
      tick();
    end
    nvec++; if (fifo_count !== 12'd0 || mcount != 0) begin nerr++; $display("FAIL drain_empty: got cnt=%0d model=%0d want 0 0", fifo_count, mcount); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      wr_if.valid = 1'($urandom_range(0, 1));
      rd_if.ready = 1'($urandom_range(0, 1));
      wr_if.data = {8{$urandom()}};
      #1;
      if (rd_if.valid && rd_if.ready) begin
        nvec++; if (sb.size() == 0 || rd_if.data !== sb[0]) begin nerr++; $display("FAIL random_data cycle %0d: got %0h want %0h", i, rd_if.data, (sb.size() != 0) ? sb[0] : {DW{1'b0}}); end
      end
      tick();
      nvec++; if (fifo_count !== 12'(mcount)) begin nerr++; $display("FAIL random_count cycle %0d: got %0d want %0d", i, fifo_count, mcount); end
    end
    wr_if.valid = 1'b0;
    rd_if.ready = 1'b1;
    for (int k = 0; k < 700 && mcount != 0; k++) begin
      #1;
      if (rd_if.valid) begin
        nvec++; if (sb.size() == 0 || rd_if.data !== sb[0]) begin nerr++; $display("FAIL random_drain: got %0h want %0h", rd_if.data, (sb.size() != 0) ? sb[0] : {DW{1'b0}}); end
      end
      tick();
    end
    nvec++; if (fifo_count !== 12'd0) begin nerr++; $display("FAIL random_empty: got %0d want 0", fifo_count); end
  endtask

  task automatic test_reset_mid();
    rd_if.ready = 1'b0;
    for (int i = 0; i < 301; i++) begin
      wr_if.valid = 1'b1;
      wr_if.data = {8{32'h3000_0000 + 32'(i)}};
      #1;
      tick();
    end
    wr_if.valid = 1'b0;
    rd_if.ready = 1'b1;
    #1;
    nvec++; if (ram_re !== 1'b1) begin nerr++; $display("FAIL mid_issue: got %0b want 1", ram_re); end
    tick();
    rd_if.ready = 1'b0;
    #1;
    nvec++; if (fifo_count !== 12'd300) begin nerr++; $display("FAIL mid_count: got %0d want 300", fifo_count); end
    rst = 1'b1;
    #1;
    nvec++; if (rd_if.valid !== 1'b0 || fifo_count !== 12'd0 || ram_used !== 10'd0) begin nerr++; $display("FAIL mid_reset: got valid=%0b cnt=%0d used=%0d want 0 0 0", rd_if.valid, fifo_count, ram_used); end
    nvec++; if (ram_re !== 1'b0 || wr_if.ready !== 1'b0) begin nerr++; $display("FAIL mid_reset_hs: got re=%0b ready=%0b want 0 0", ram_re, wr_if.ready); end
    clear_model();
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr_if.valid = 1'b1;
    wr_if.data = {8{32'h5A5A_0001}};
    #1;
    tick();
    wr_if.valid = 1'b0;
    rd_if.ready = 1'b1;
    for (int k = 0; k < 8 && rd_if.valid !== 1'b1; k++) tick();
    nvec++; if (rd_if.valid !== 1'b1 || rd_if.data !== {8{32'h5A5A_0001}}) begin nerr++; $display("FAIL mid_after: got valid=%0b data=%0h want 1 5a5a0001..", rd_if.valid, rd_if.data); end
    tick();
    nvec++; if (fifo_count !== 12'd0) begin nerr++; $display("FAIL mid_after_empty: got %0d want 0", fifo_count); end
  endtask

`ifdef NV_RAM_FIFO_CTRL_FLUSH_EN
  task automatic test_flush();
    rd_if.ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      wr_if.valid = 1'b1;
      wr_if.data = {8{32'h4000_0000 + 32'(i)}};
      #1;
      tick();
    end
    #1;
    nvec++; if (fifo_count !== 12'd40) begin nerr++; $display("FAIL flush_pre: got %0d want 40", fifo_count); end
    flush = 1'b1;
    wr_if.data = {8{32'hBAD0_BAD0}};
    #1;
    nvec++; if (wr_if.ready !== 1'b0 || ram_we !== 1'b0 || ram_re !== 1'b0 || rd_if.valid !== 1'b0) begin nerr++; $display("FAIL flush_hs: got ready=%0b we=%0b re=%0b valid=%0b want 0 0 0 0", wr_if.ready, ram_we, ram_re, rd_if.valid); end
    tick();
    flush = 1'b0;
    clear_model();
    wr_if.data = {8{32'h3C3C_3C3C}};
    #1;
    nvec++; if (fifo_count !== 12'd0 || ram_wa !== 9'd0) begin nerr++; $display("FAIL flush_count: got cnt=%0d wa=%0d want 0 0", fifo_count, ram_wa); end
    tick();
    wr_if.valid = 1'b0;
    rd_if.ready = 1'b1;
    for (int k = 0; k < 8 && rd_if.valid !== 1'b1; k++) tick();
    nvec++; if (rd_if.valid !== 1'b1 || rd_if.data !== {8{32'h3C3C_3C3C}}) begin nerr++; $display("FAIL flush_first: got valid=%0b data=%0h want 1 3c3c..", rd_if.valid, rd_if.data); end
    tick();
    nvec++; if (fifo_count !== 12'd0) begin nerr++; $display("FAIL flush_empty: got %0d want 0", fifo_count); end
  endtask
`endif

  initial begin
    nvec = 0;
    nerr = 0;
    rst = 1'b1;
    wr_if.valid = 1'b0;
    wr_if.data = {DW{1'b0}};
    rd_if.ready = 1'b0;
    pwrbus_ram_pd = 32'h0;
`ifdef NV_RAM_FIFO_CTRL_FLUSH_EN
    flush = 1'b0;
`endif
    clear_model();
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef NV_RAM_FIFO_CTRL_FLUSH_EN
    test_flush();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
